// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the E-stage multiply/divide unit and the
// E-stage control decoder.
//   md_op_e         MDOp encodings (101-111 are not listed and act as none)
//   MD_WIDTH        default operand / HI / LO width
//   MD_MULT_CYCLES  default busy cycles for mult/multu
//   MD_DIV_CYCLES   default busy cycles for div/divu
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULTU = 3'b001,
        MD_MULT  = 3'b010,
        MD_DIVU  = 3'b011,
        MD_DIV   = 3'b100
    } md_op_e;

    localparam int unsigned MD_WIDTH       = 32;
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage control/operand bundle between the pipeline and e_mdu.
//   MDOp, MDWE, MDAddrOp, req, A, B : pipeline -> MDU
//   start, busy, rdata              : MDU -> pipeline / hazard unit
// master: pipeline side; slave: MDU side.
interface e_mdu_if #(
    parameter int unsigned WIDTH = md_pkg::MD_WIDTH
) ();

    logic [2:0]       MDOp;
    logic             MDWE;
    logic             MDAddrOp;
    logic             req;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] rdata;

    modport master (
        output MDOp, MDWE, MDAddrOp, req, A, B,
        input  start, busy, rdata
    );

    modport slave (
        input  MDOp, MDWE, MDAddrOp, req, A, B,
        output start, busy, rdata
    );

endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, reset  : clock, asynchronous active-high reset
//   md.MDOp     : 000 none, 001 multu, 010 mult, 011 divu, 100 div
//   md.MDWE     : mthi/mtlo write enable, md.MDAddrOp selects HI (1) / LO (0)
//   md.req      : exception/interrupt this cycle, blocks start and MDWE
//   md.A, md.B  : forwarded rs / rt operands
//   md.start    : valid operation requested and no req (combinational)
//   md.busy     : operation in flight (from the counter register)
//   md.rdata    : HI when MDAddrOp = 1, else LO (combinational)
// The result is computed at accept time and parked in pending registers;
// the counter alone models latency and commits the result when it expires.
module e_mdu
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = MD_WIDTH,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave md
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                    op_valid, is_div, busy;
    logic [WIDTH-1:0]        res_hi, res_lo;
    logic                    res_wr;
    logic [2*WIDTH-1:0]      a_ext, b_ext, prod;
    logic [WIDTH-1:0]        b_safe, q_u, r_u;
    logic signed [WIDTH-1:0] q_s, r_s;

    always_comb begin
        op_valid = 1'b0;
        is_div   = 1'b0;
        case (md.MDOp)
            MD_MULTU, MD_MULT: op_valid = 1'b1;
            MD_DIVU, MD_DIV: begin
                op_valid = 1'b1;
                is_div   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (cnt_q != '0);
    assign md.busy  = busy;
    assign md.start = op_valid && !md.req;
    assign md.rdata = md.MDAddrOp ? hi_q : lo_q;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // are then correct for both signed and unsigned multiply.
    always_comb begin
        if (md.MDOp == MD_MULT) begin
            a_ext = {{WIDTH{md.A[WIDTH-1]}}, md.A};
            b_ext = {{WIDTH{md.B[WIDTH-1]}}, md.B};
        end else begin
            a_ext = {{WIDTH{1'b0}}, md.A};
            b_ext = {{WIDTH{1'b0}}, md.B};
        end
    end
    assign prod = a_ext * b_ext;

    // Zero divisor is replaced by 1 so the dividers never see it; the
    // result is discarded via res_wr anyway.
    assign b_safe = (md.B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : md.B;
    assign q_u    = md.A / b_safe;
    assign r_u    = md.A % b_safe;
    assign q_s    = $signed(md.A) / $signed(b_safe);
    assign r_s    = $signed(md.A) % $signed(b_safe);

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b1;
        case (md.MDOp)
            MD_MULTU, MD_MULT: {res_hi, res_lo} = prod;
            MD_DIVU: begin
                res_lo = q_u;
                res_hi = r_u;
                res_wr = (md.B != '0);
            end
            MD_DIV: begin
                if (md.A == MIN_NEG && md.B == '1) begin
                    res_lo = MIN_NEG;
                    res_hi = '0;
                end else begin
                    res_lo = q_s;
                    res_hi = r_s;
                end
                res_wr = (md.B != '0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;
        if (busy) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            if (md.MDWE && !md.req) begin
                if (md.MDAddrOp) hi_d = md.A;
                else             lo_d = md.A;
            end
            if (md.start) begin
                pend_hi_d = res_hi;
                pend_lo_d = res_lo;
                pend_wr_d = res_wr;
                cnt_d     = is_div ? DIV_LOAD : MULT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed test of e_mdu with default latencies (dut) and with
// single-cycle latencies (dut1). Inputs change and outputs are sampled on
// the falling edge; the design acts on the rising edge.
module tb_e_mdu;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset;

    e_mdu_if #(.WIDTH(32)) mif0 ();
    e_mdu_if #(.WIDTH(32)) mif1 ();

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md(mif0.slave)
    );
    e_mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .md(mif1.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_busy(input bit u1);
        return u1 ? mif1.busy : mif0.busy;
    endfunction

    function automatic logic get_start(input bit u1);
        return u1 ? mif1.start : mif0.start;
    endfunction

    task automatic set_in(input bit u1, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (u1) begin
            mif1.MDOp = op; mif1.A = a; mif1.B = b;
        end else begin
            mif0.MDOp = op; mif0.A = a; mif0.B = b;
        end
    endtask

    task automatic read_hl(input bit u1, output logic [31:0] hi, output logic [31:0] lo);
        if (u1) begin
            mif1.MDAddrOp = 1'b1; #1 hi = mif1.rdata;
            mif1.MDAddrOp = 1'b0; #1 lo = mif1.rdata;
        end else begin
            mif0.MDAddrOp = 1'b1; #1 hi = mif0.rdata;
            mif0.MDAddrOp = 1'b0; #1 lo = mif0.rdata;
        end
    endtask

    // Called at a falling edge; returns at the falling edge right after accept.
    task automatic start_op(input bit u1, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input string tag);
        set_in(u1, op, a, b);
        #1 chk({tag, "_start"}, get_start(u1), 1'b1);
        @(negedge clk);
        set_in(u1, MD_NONE, 32'h0, 32'h0);
    endtask

    task automatic wait_done(input bit u1, input int unsigned n0, input int unsigned exp_n, input string tag);
        int unsigned n = n0;
        while (get_busy(u1) && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, n, exp_n);
    endtask

    task automatic run_op(input bit u1, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag);
        logic [31:0] hi, lo;
        start_op(u1, op, a, b, tag);
        wait_done(u1, 0, exp_n, tag);
        read_hl(u1, hi, lo);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hi, lo;
        mif0.MDOp = MD_NONE; mif0.MDWE = 1'b0; mif0.MDAddrOp = 1'b0; mif0.req = 1'b0;
        mif0.A = '0; mif0.B = '0;
        mif1.MDOp = MD_NONE; mif1.MDWE = 1'b0; mif1.MDAddrOp = 1'b0; mif1.req = 1'b0;
        mif1.A = '0; mif1.B = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state; start is purely combinational on its inputs.
        chk("rst_busy", mif0.busy, 1'b0);
        read_hl(0, hi, lo);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        mif0.MDOp = MD_MULT;
        #1 chk("rst_start_on", mif0.start, 1'b1);
        mif0.MDOp = MD_NONE;
        #1 chk("rst_start_off", mif0.start, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(0, MD_MULT, 32'hFFFF_FFFE, 32'h3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");

        // mthi then mtlo on consecutive cycles.
        mif0.MDWE = 1'b1; mif0.MDAddrOp = 1'b1; mif0.A = 32'h1234_5678;
        @(negedge clk);
        mif0.MDAddrOp = 1'b0; mif0.A = 32'h9;
        @(negedge clk);
        mif0.MDWE = 1'b0; mif0.A = '0;
        read_hl(0, hi, lo);
        chk("mthi", hi, 32'h1234_5678);
        chk("mtlo", lo, 32'h9);
        @(negedge clk);

        run_op(0, MD_DIV,  32'hFFFF_FFF9, 32'h2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(0, MD_DIVU, 32'h7,         32'h0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu0");
        run_op(0, MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,         32'h8000_0000, "divovf");
        run_op(0, MD_DIVU, 32'hFFFF_FFFF, 32'h10,        10, 32'hF,         32'h0FFF_FFFF, "divu");

        // Reserved encoding acts as none.
        mif0.MDOp = 3'b101;
        #1 chk("rsv_start", mif0.start, 1'b0);
        @(negedge clk);
        chk("rsv_busy", mif0.busy, 1'b0);

        // req blocks start and mthi in the same cycle.
        mif0.MDOp = MD_MULT; mif0.req = 1'b1;
        mif0.MDWE = 1'b1; mif0.MDAddrOp = 1'b1; mif0.A = 32'hAAAA;
        #1 chk("req_start", mif0.start, 1'b0);
        @(negedge clk);
        chk("req_busy", mif0.busy, 1'b0);
        mif0.MDOp = MD_NONE; mif0.req = 1'b0; mif0.MDWE = 1'b0; mif0.A = '0;
        read_hl(0, hi, lo);
        chk("req_mthi", hi, 32'hF);
        @(negedge clk);

        // MDWE while busy is ignored.
        start_op(0, MD_MULT, 32'h2, 32'h3, "mdwe_busy");
        mif0.MDWE = 1'b1; mif0.MDAddrOp = 1'b1; mif0.A = 32'hDEAD;
        @(negedge clk);
        #1 chk("mdwe_busy_hold", mif0.rdata, 32'hF);
        mif0.MDWE = 1'b0; mif0.MDAddrOp = 1'b0; mif0.A = '0;
        wait_done(0, 1, 5, "mdwe_busy");
        read_hl(0, hi, lo);
        chk("mdwe_busy_hi", hi, 32'h0);
        chk("mdwe_busy_lo", lo, 32'h6);
        @(negedge clk);

        // req pulse mid-operation does not cancel it.
        start_op(0, MD_MULT, 32'h1_0000, 32'h1_0000, "req_mid");
        mif0.req = 1'b1;
        @(negedge clk);
        mif0.req = 1'b0;
        wait_done(0, 1, 5, "req_mid");
        read_hl(0, hi, lo);
        chk("req_mid_hi", hi, 32'h1);
        chk("req_mid_lo", lo, 32'h0);
        @(negedge clk);

        // Single-cycle latency instance.
        run_op(1, MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0,         32'h8000_0000, "u1_divovf");
        run_op(1, MD_MULT, 32'hFFFF_FFFE, 32'h3,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "u1_mult");

        run_op(0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h1, "multu");

        // Asynchronous reset three cycles into a div.
        start_op(0, MD_DIV, 32'd100, 32'd7, "rst_mid");
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("rst_mid_busy", mif0.busy, 1'b0);
        read_hl(0, hi, lo);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_after_busy", mif0.busy, 1'b0);
        read_hl(0, hi, lo);
        chk("rst_after_hi", hi, 32'h0);
        chk("rst_after_lo", lo, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
